float_accum_seq: RTL and testbench
==================================

# float_accum_seq

Sequencer that drives one shared combinational float adder (`float_adder`, same `EXP_WIDTH`/`SFD_WIDTH`) to reduce a streamed packet of floats into a single sum. It sits between a producer stream (e.g. dot-product partial products) and a downstream consumer. It accepts one operand per cycle, holds the running sum in a register, and emits the total with a beat count when the packet's last beat is accepted.

## Interface
Parameters:
- `EXP_WIDTH`, 8, exponent width of the float format.
- `SFD_WIDTH`, 7, stored significand width; word width `W = EXP_WIDTH+SFD_WIDTH+1`.
- `CNT_WIDTH`, 8, width of the beat counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  W  operand.
- `in_last`  in  1  marks the final beat of a packet.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  W  packet sum.
- `out_count`  out  CNT_WIDTH  beats in the packet, saturating.
- `add_a`  out  W  adder operand A, equal to the accumulator register.
- `add_b`  out  W  adder operand B, equal to `in_data`.
- `add_sum`  in  W  adder result, combinational from `add_a`/`add_b`.

## Operation
- States:
  - IDLE: no packet open; accumulator = +0.
  - ACCUM: packet open.
  - HOLD: result presented.
- Accept: `in_fire = in_valid & in_ready`. `in_ready = ~rst & (state != HOLD)`.
- On `in_fire` with `~in_last`:
  - `acc <= add_sum`.
  - `cnt <= sat(cnt+1)`.
  - state -> ACCUM.
- On `in_fire` with `in_last`:
  - `out_data <= add_sum`.
  - `out_count <= sat(cnt+1)`.
  - `out_valid <= 1`.
  - `acc <= 0`, `cnt <= 0`.
  - state -> HOLD.
  - Applies from IDLE as well: a single-beat packet yields `in_data + (+0)`.
- HOLD: `out_valid`, `out_data` and `out_count` stay stable until `out_valid & out_ready`. Then `out_valid <= 0` and state -> IDLE.
- No `in_fire` in IDLE/ACCUM: all registers hold. Bubbles inside a packet are allowed.
- Saturation: `sat(x)` clamps at `2^CNT_WIDTH-1`. The sum keeps accumulating past saturation.
- Arithmetic:
  - Rounding, inf/NaN and subnormal handling are exactly the adder's.
  - The block never inspects values.
  - The accumulator starts at +0, so an all-(-0) packet sums to +0.
  - NaN propagates as the adder's canonical NaN (exp all ones, sfd = 1).
- Reset: `rst` high in any state forces state IDLE, `acc=0`, `cnt=0`, `out_valid=0`, `out_data=0`, `out_count=0`, `in_ready=0`. Any open packet or unconsumed result is discarded.

## Timing
- Throughput: one operand per cycle while in IDLE/ACCUM.
- Latency: `out_valid` rises the cycle after the last beat's `in_fire`.
- Bubble: `in_ready` is 0 for every HOLD cycle. It returns to 1 the cycle after the output handshake, so the minimum gap is 1 cycle between a packet's last beat and the next packet's first beat.
- Critical path: acc register -> adder -> acc register. Single cycle, no internal pipelining.
- `out_*` are registered. `in_ready` and `add_a`/`add_b` are combinational from state, `acc` and `in_data` only; none depends on `out_ready`.
- `in_valid` may drop between beats. `in_data` is sampled only on `in_fire`.
- Simultaneous events: HOLD blocks input, so an output handshake and `in_fire` never occur in the same cycle.

## Test plan
- bf16 packet 0x3F80, 0x4000, 0x3F00 (last), 1 beat/cycle -> `out_data`=0x4060 (3.5), `out_count`=3, `out_valid` one cycle after the last beat.
- Single beat 0xC040 with `in_last`=1 from IDLE -> `out_data`=0xC040, `out_count`=1. Then hold `out_ready`=0 for 5 cycles -> outputs stable and `in_ready`=0 throughout.
- Packet 0x7F80, 0xFF80 (last) -> `out_data`=0x7F81 (NaN). Packet 0x7F80, 0x3F80 (last) -> 0x7F80.
- Assert `rst` for 1 cycle after 2 beats of a packet, then send 0x4000 (last) -> `out_data`=0x4000, `out_count`=1.
- 300 beats of 0x0000 with `CNT_WIDTH`=8, the last with `in_last` -> `out_count`=255, `out_data`=0x0000.
- Back-to-back packets with random `in_valid`/`out_ready` gaps, checked against a scoreboard that reduces each packet through a reference model of the adder.

Source files
------------

// File: rtl/float_accum_seq.sv
// rtl/float_accum_seq.sv - streams a packet of floats through a shared adder into one registered sum
module float_accum_seq #(
    parameter int EXP_WIDTH = 8,
    parameter int SFD_WIDTH = 7,
    parameter int CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+SFD_WIDTH:0]   in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+SFD_WIDTH:0]   out_data,
    output logic [CNT_WIDTH-1:0]           out_count,
    output logic [EXP_WIDTH+SFD_WIDTH:0]   add_a,
    output logic [EXP_WIDTH+SFD_WIDTH:0]   add_b,
    input  logic [EXP_WIDTH+SFD_WIDTH:0]   add_sum
);

    localparam int W = EXP_WIDTH + SFD_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [W-1:0]         acc, acc_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next, cnt_sat;
    logic                 out_valid_next;
    logic [W-1:0]         out_data_next;
    logic [CNT_WIDTH-1:0] out_count_next;
    logic                 in_fire;

    assign in_ready = ~rst & (state != HOLD);
    assign in_fire  = in_valid & in_ready;
    assign add_a    = acc;
    assign add_b    = in_data;
    // Beat count sticks at all-ones; the sum itself keeps accumulating.
    assign cnt_sat  = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + 1'b1;

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        cnt_next       = cnt;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        out_count_next = out_count;
        case (state)
            IDLE, ACCUM: begin
                if (in_fire) begin
                    if (in_last) begin
                        out_data_next  = add_sum;
                        out_count_next = cnt_sat;
                        out_valid_next = 1'b1;
                        acc_next       = '0;
                        cnt_next       = '0;
                        state_next     = HOLD;
                    end else begin
                        acc_next   = add_sum;
                        cnt_next   = cnt_sat;
                        state_next = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_valid & out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            out_count <= out_count_next;
        end
    end

endmodule

// File: tb/tb_float_accum_seq.sv
// tb/tb_float_accum_seq.sv - bf16 accumulation bench with a behavioural adder and packet scoreboard
module tb_float_accum_seq;

    localparam int W  = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic [W-1:0]  add_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    float_accum_seq #(.EXP_WIDTH(8), .SFD_WIDTH(7), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
    );

    function automatic real p2(int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real bf_to_real(logic [15:0] a);
        real m;
        if (a[14:7] == 8'd0) m = real'(int'(a[6:0])) * p2(-133);
        else                 m = real'(128 + int'(a[6:0])) * p2(int'(a[14:7]) - 134);
        return a[15] ? -m : m;
    endfunction

    // IEEE-style bf16 add, round-to-nearest-even, subnormals kept, canonical NaN 0x7F81.
    function automatic logic [15:0] bf_add(logic [15:0] a, logic [15:0] b);
        real         x, q, r;
        logic [63:0] db;
        logic [44:0] rest;
        int          e, v;
        logic        a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
        b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
        a_inf = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
        b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
        if (a_nan || b_nan) return 16'h7F81;
        if (a_inf && b_inf) return (a[15] == b[15]) ? a : 16'h7F81;
        if (a_inf) return a;
        if (b_inf) return b;
        x = bf_to_real(a) + bf_to_real(b);
        if (x == 0.0) return (a[15] & b[15]) ? 16'h8000 : 16'h0000;
        db = $realtobits(x);
        e  = int'(db[62:52]) - 1023 + 127;
        if (e >= 1) begin
            v    = e * 128 + int'(db[51:45]);
            rest = db[44:0];
            if (rest > {1'b1, 44'd0} || (rest == {1'b1, 44'd0} && v[0])) v = v + 1;
            if (v >= 255 * 128) return {db[63], 15'h7F80};
            return {db[63], v[14:0]};
        end
        q = (x < 0.0 ? -x : x) * p2(133);
        r = $floor(q);
        if ((q - r) > 0.5 || ((q - r) == 0.5 && (int'(r) % 2 == 1))) r = r + 1.0;
        v = int'(r);
        return {db[63], v[14:0]};
    endfunction

    assign add_sum = bf_add(add_a, add_b);

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_beat(logic [15:0] d, logic last, int gap);
        int n = 0;
        for (int i = 0; i < gap; i++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(string tag, logic [15:0] ed, logic [CW-1:0] ec, int hold);
        int n = 0;
        out_ready = 1'b0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_data"}, out_data, ed);
            check({tag, "_hold_cnt"}, out_count, ec);
            check({tag, "_hold_rdy"}, in_ready, 0);
            @(negedge clk);
        end
        check({tag, "_data"}, out_data, ed);
        check({tag, "_count"}, out_count, ec);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_drop"}, out_valid, 0);
        check({tag, "_rdy_back"}, in_ready, 1);
    endtask

    initial begin
        logic [15:0] pkt[$];
        logic [15:0] exp_sum;
        int          len;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_count", out_count, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_add_a", add_a, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // 1 + 2 + 0.5 at one beat per cycle
        send_beat(16'h3F80, 1'b0, 0);
        send_beat(16'h4000, 1'b0, 0);
        send_beat(16'h3F00, 1'b1, 0);
        @(negedge clk);
        check("t1_latency", out_valid, 1);
        wait_result("t1", 16'h4060, 8'd3, 0);

        send_beat(16'hC040, 1'b1, 0);
        wait_result("single", 16'hC040, 8'd1, 5);

        send_beat(16'h7F80, 1'b0, 0);
        send_beat(16'hFF80, 1'b1, 0);
        wait_result("inf_minf", 16'h7F81, 8'd2, 0);
        send_beat(16'h7F80, 1'b0, 0);
        send_beat(16'h3F80, 1'b1, 0);
        wait_result("inf_one", 16'h7F80, 8'd2, 0);

        send_beat(16'h3F80, 1'b0, 0);
        send_beat(16'h4000, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_acc", add_a, 0);
        check("midrst_out_valid", out_valid, 0);
        send_beat(16'h4000, 1'b1, 0);
        wait_result("midrst", 16'h4000, 8'd1, 0);

        send_beat(16'h8000, 1'b0, 0);
        send_beat(16'h8000, 1'b1, 0);
        wait_result("negzero", 16'h0000, 8'd2, 0);

        for (int i = 0; i < 300; i++) send_beat(16'h0000, (i == 299), 0);
        wait_result("sat", 16'h0000, 8'd255, 0);

        for (int p = 0; p < 40; p++) begin
            pkt.delete();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) pkt.push_back(16'($urandom));
                else pkt.push_back({1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)});
            end
            exp_sum = 16'h0000;
            foreach (pkt[i]) exp_sum = bf_add(exp_sum, pkt[i]);
            foreach (pkt[i]) send_beat(pkt[i], (i == len - 1), $urandom_range(0, 2));
            wait_result($sformatf("rand%0d", p), exp_sum, CW'(len), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
